list_builder: RTL and testbench

- Writer side of the linked-list summing datapath.
- Accepts a stream of N-bit values and writes them into the shared word-addressed memory as a singly linked list.
- Node layout matches the list-summing reader: value word at node address p, next-pointer word at p+1; next pointer 0 terminates the list.
- Nodes are allocated contiguously from a start address, so node k sits at head_addr+2k.
- Once done is seen, the reader can be pointed at head_addr.

---
 rtl/list_builder.sv | 164 ++++++++++++++++
 tb/tb_list_builder.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/list_builder.sv
// Writer side of the linked-list summing datapath: streams values into memory as nodes {value, next}.
// Optional running checksum of written values is enabled by defining LIST_BUILDER_CHECKSUM_EN.
module list_builder #(
    parameter int N = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic [N-1:0] head_addr_i,
    input  logic         in_valid_i,
    input  logic [N-1:0] in_data_i,
    input  logic         in_last_i,
    output logic         in_ready_o,
    output logic         mem_we_o,
    output logic [N-1:0] mem_addr_o,
    output logic [N-1:0] mem_wdata_o,
    output logic         busy_o,
    output logic         done_o,
    output logic         err_o,
    output logic [N-1:0] count_o,
    output logic [N-1:0] checksum_o
);

    typedef enum logic [2:0] {IDLE, WAIT, WR_VAL, WR_NEXT, FIN} state_t;

    localparam logic [N-1:0] ADDR_ZERO = '0;
    localparam logic [N-1:0] ADDR_TOP = '1;
    // A node at or above this address leaves no room for another {value, next} pair.
    localparam logic [N-1:0] LAST_NODE_LIMIT = ADDR_TOP - N'(2);

    state_t       state_q, state_d;
    logic [N-1:0] ptr_q, ptr_d;
    logic [N-1:0] latchedData_q, latchedData_d;
    logic         latchedLast_q, latchedLast_d;
    logic [N-1:0] count_q, count_d;
    logic [N-1:0] memAddr_q, memAddr_d;
    logic [N-1:0] memWdata_q, memWdata_d;
    logic         err_q, err_d;
    logic         headOk;

    assign headOk = (head_addr_i != ADDR_ZERO) && (head_addr_i != ADDR_TOP);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            latchedData_q <= '0;
            latchedLast_q <= 1'b0;
            count_q       <= '0;
            memAddr_q     <= '0;
            memWdata_q    <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            latchedData_q <= latchedData_d;
            latchedLast_q <= latchedLast_d;
            count_q       <= count_d;
            memAddr_q     <= memAddr_d;
            memWdata_q    <= memWdata_d;
            err_q         <= err_d;
        end
    end

    // Address/data buses pass the registered copy through, so they hold while mem_we is low.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        latchedData_d = latchedData_q;
        latchedLast_d = latchedLast_q;
        count_d       = count_q;
        memAddr_d     = memAddr_q;
        memWdata_d    = memWdata_q;
        err_d         = err_q;
        in_ready_o    = 1'b0;
        mem_we_o      = 1'b0;
        done_o        = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (!headOk) begin
                        err_d   = 1'b1;
                        state_d = FIN;
                    end else begin
                        ptr_d   = head_addr_i;
                        count_d = '0;
                        err_d   = 1'b0;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    latchedData_d = in_data_i;
                    latchedLast_d = in_last_i;
                    state_d       = WR_VAL;
                end
            end
            WR_VAL: begin
                mem_we_o   = 1'b1;
                memAddr_d  = ptr_q;
                memWdata_d = latchedData_q;
                state_d    = WR_NEXT;
            end
            WR_NEXT: begin
                mem_we_o  = 1'b1;
                memAddr_d = ptr_q + N'(1);
                count_d   = count_q + N'(1);
                if (latchedLast_q) begin
                    memWdata_d = '0;
                    state_d    = FIN;
                end else if (ptr_q >= LAST_NODE_LIMIT) begin
                    memWdata_d = '0;
                    err_d      = 1'b1;
                    state_d    = FIN;
                end else begin
                    memWdata_d = ptr_q + N'(2);
                    ptr_d      = ptr_q + N'(2);
                    state_d    = WAIT;
                end
            end
            FIN: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_addr_o  = memAddr_d;
    assign mem_wdata_o = memWdata_d;
    assign busy_o      = (state_q != IDLE);
    assign err_o       = err_q;
    assign count_o     = count_q;

`ifdef LIST_BUILDER_CHECKSUM_EN
    logic [N-1:0] checksum_q, checksum_d;

    // Restarts only on an accepted start so it matches the reader's sum for this list.
    always_comb begin
        checksum_d = checksum_q;
        if (state_q == IDLE && start_i && headOk) begin
            checksum_d = '0;
        end else if (state_q == WR_VAL) begin
            checksum_d = checksum_q + latchedData_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum_o = checksum_q;
`else
    assign checksum_o = '0;
`endif

endmodule

// File: tb/tb_list_builder.sv
// Self-checking bench for list_builder: a list-level model predicts every memory write
// and the end-of-list count/err/checksum, checked on every cycle by one compare process.
module tb_list_builder;

   logic       clk = 1'b0;
   logic       rst_i;
   logic       start_i;
   logic [7:0] head_addr_i;
   logic       in_valid_i;
   logic [7:0] in_data_i;
   logic       in_last_i;
   logic       in_ready_o;
   logic       mem_we_o;
   logic [7:0] mem_addr_o;
   logic [7:0] mem_wdata_o;
   logic       busy_o;
   logic       done_o;
   logic       err_o;
   logic [7:0] count_o;
   logic [7:0] checksum_o;

`ifdef LIST_BUILDER_CHECKSUM_EN
   localparam logic [7:0] BASIC_SUM = 8'd15;
`else
   localparam logic [7:0] BASIC_SUM = 8'd0;
`endif

   list_builder #(.N(8)) dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .start_i     (start_i),
      .head_addr_i (head_addr_i),
      .in_valid_i  (in_valid_i),
      .in_data_i   (in_data_i),
      .in_last_i   (in_last_i),
      .in_ready_o  (in_ready_o),
      .mem_we_o    (mem_we_o),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .err_o       (err_o),
      .count_o     (count_o),
      .checksum_o  (checksum_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int doneSeen = 0;
   int doneCyc = 0;
   int hsCyc = 0;
   int readySeen = 0;

   // List model state: expected write stream plus end-of-list results.
   logic [15:0] expQ[$];
   logic [7:0]  tbMem[256];
   logic [7:0]  vals[8];
   int          mCount = 0;
   logic        mErr = 1'b0;
   logic [7:0]  mSum = 8'h00;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] expChecksum();
`ifdef LIST_BUILDER_CHECKSUM_EN
      return mSum;
`else
      return 8'h00;
`endif
   endfunction

   // Builds the expected write stream from list rules: node k at head+2k, a node needs
   // both its words inside memory, and the list ends at the last value or when full.
   task automatic modelList(input logic [7:0] head, input int n, input int lastIdx, output int nAcc);
      int addr;
      nAcc = 0;
      if (head == 8'h00 || head == 8'hFF) begin
         mErr = 1'b1;
         return;
      end
      mErr = 1'b0;
      mCount = 0;
      mSum = 8'h00;
      for (int k = 0; k < n; k++) begin
         addr = int'(head) + 2 * k;
         nAcc++;
         mCount++;
         mSum = mSum + vals[k];
         expQ.push_back({8'(addr), vals[k]});
         if (k == lastIdx) begin
            expQ.push_back({8'(addr + 1), 8'h00});
            break;
         end else if (addr + 3 > 255) begin
            expQ.push_back({8'(addr + 1), 8'h00});
            mErr = 1'b1;
            break;
         end else begin
            expQ.push_back({8'(addr + 1), 8'(addr + 2)});
         end
      end
   endtask

   // Compare process: every write must be the next predicted one; done carries the results.
   always @(negedge clk) begin
      logic [15:0] e;
      if (in_ready_o) readySeen++;
      if (mem_we_o) begin
         checkOutput("write expected", {31'd0, expQ.size() != 0}, 32'd1);
         if (expQ.size() != 0) begin
            e = expQ.pop_front();
            checkOutput("write addr", {24'd0, mem_addr_o}, {24'd0, e[15:8]});
            checkOutput("write data", {24'd0, mem_wdata_o}, {24'd0, e[7:0]});
         end
         tbMem[mem_addr_o] = mem_wdata_o;
      end
      if (done_o) begin
         doneSeen++;
         doneCyc = cyc;
         checkOutput("done count", {24'd0, count_o}, 32'(mCount[7:0]));
         checkOutput("done err", {31'd0, err_o}, {31'd0, mErr});
         checkOutput("done checksum", {24'd0, checksum_o}, {24'd0, expChecksum()});
         checkOutput("done busy", {31'd0, busy_o}, 32'd1);
      end
   end

   task automatic checkResetOutputs();
      checkOutput("reset in_ready", {31'd0, in_ready_o}, 32'd0);
      checkOutput("reset mem_we", {31'd0, mem_we_o}, 32'd0);
      checkOutput("reset mem_addr", {24'd0, mem_addr_o}, 32'd0);
      checkOutput("reset mem_wdata", {24'd0, mem_wdata_o}, 32'd0);
      checkOutput("reset busy", {31'd0, busy_o}, 32'd0);
      checkOutput("reset done", {31'd0, done_o}, 32'd0);
      checkOutput("reset err", {31'd0, err_o}, 32'd0);
      checkOutput("reset count", {24'd0, count_o}, 32'd0);
      checkOutput("reset checksum", {24'd0, checksum_o}, 32'd0);
   endtask

   // Called just after a rising edge; returns with the handshake edge just passed.
   task automatic sendValue(input logic [7:0] d, input logic last, input int budget, output logic acc);
      acc = 1'b0;
      in_valid_i = 1'b1;
      in_data_i = d;
      in_last_i = last;
      for (int i = 0; i < budget && !acc; i++) begin
         @(negedge clk);
         if (in_ready_o) begin
            acc = 1'b1;
            hsCyc = cyc;
         end
         @(posedge clk);
         #1;
      end
      in_valid_i = 1'b0;
   endtask

   task automatic pulseStart(input logic [7:0] head);
      start_i = 1'b1;
      head_addr_i = head;
      @(posedge clk);
      #1;
      start_i = 1'b0;
   endtask

   task automatic applyStimulus(input string tag, input logic [7:0] head, input int n, input int lastIdx);
      int   nAcc;
      int   doneBefore;
      logic acc;
      modelList(head, n, lastIdx, nAcc);
      doneBefore = doneSeen;
      pulseStart(head);
      for (int k = 0; k < n; k++) begin
         sendValue(vals[k], k == lastIdx, 20, acc);
         checkOutput($sformatf("%s accept %0d", tag, k), {31'd0, acc}, {31'd0, k < nAcc});
      end
      repeat (8) @(posedge clk);
      #1;
      checkOutput({tag, " done once"}, doneSeen - doneBefore, 32'd1);
      checkOutput({tag, " writes drained"}, expQ.size(), 32'd0);
   endtask

   initial begin
      int   doneBefore;
      logic acc;
      for (int i = 0; i < 256; i++) tbMem[i] = 8'h5A;
      rst_i = 1'b0;
      start_i = 1'b0;
      head_addr_i = 8'h00;
      in_valid_i = 1'b0;
      in_data_i = 8'h00;
      in_last_i = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkResetOutputs();
      @(posedge clk);
      #1;
      rst_i = 1'b1;
      @(posedge clk);
      #1;

      $display("[TB] basic list");
      vals[0] = 8'd3; vals[1] = 8'd5; vals[2] = 8'd7;
      applyStimulus("basic", 8'h10, 3, 2);
      checkOutput("basic mem 10", {24'd0, tbMem[8'h10]}, 32'h03);
      checkOutput("basic mem 11", {24'd0, tbMem[8'h11]}, 32'h12);
      checkOutput("basic mem 13", {24'd0, tbMem[8'h13]}, 32'h14);
      checkOutput("basic mem 14", {24'd0, tbMem[8'h14]}, 32'h07);
      checkOutput("basic mem 15", {24'd0, tbMem[8'h15]}, 32'h00);
      checkOutput("basic count", {24'd0, count_o}, 32'd3);
      checkOutput("basic err", {31'd0, err_o}, 32'd0);
      checkOutput("basic checksum", {24'd0, checksum_o}, {24'd0, BASIC_SUM});

      $display("[TB] single node");
      vals[0] = 8'hAA;
      applyStimulus("single", 8'h40, 1, 0);
      checkOutput("single latency", doneCyc - hsCyc, 32'd3);
      checkOutput("single mem 40", {24'd0, tbMem[8'h40]}, 32'hAA);
      checkOutput("single mem 41", {24'd0, tbMem[8'h41]}, 32'h00);
      checkOutput("single count", {24'd0, count_o}, 32'd1);

      $display("[TB] bad head");
      readySeen = 0;
      applyStimulus("bad00", 8'h00, 0, -1);
      checkOutput("bad00 err", {31'd0, err_o}, 32'd1);
      applyStimulus("badFF", 8'hFF, 0, -1);
      checkOutput("badFF err", {31'd0, err_o}, 32'd1);
      checkOutput("bad in_ready", readySeen, 32'd0);

      $display("[TB] top of memory");
      vals[0] = 8'd1; vals[1] = 8'd2; vals[2] = 8'd3;
      applyStimulus("top", 8'hFB, 3, -1);
      checkOutput("top mem FC", {24'd0, tbMem[8'hFC]}, 32'hFD);
      checkOutput("top mem FE", {24'd0, tbMem[8'hFE]}, 32'h00);
      checkOutput("top count", {24'd0, count_o}, 32'd2);
      checkOutput("top err", {31'd0, err_o}, 32'd1);

      $display("[TB] backpressure and ignored start");
      vals[0] = 8'h09; vals[1] = 8'h21;
      begin
         int nAcc;
         modelList(8'h80, 2, 1, nAcc);
      end
      doneBefore = doneSeen;
      pulseStart(8'h80);
      for (int i = 0; i < 10; i++) begin
         if (i == 4) begin
            start_i = 1'b1;
            head_addr_i = 8'h00;
         end else begin
            start_i = 1'b0;
         end
         @(negedge clk);
         checkOutput("hold in_ready", {31'd0, in_ready_o}, 32'd1);
         @(posedge clk);
         #1;
      end
      start_i = 1'b0;
      sendValue(vals[0], 1'b0, 20, acc);
      checkOutput("bp accept 0", {31'd0, acc}, 32'd1);
      start_i = 1'b1;
      head_addr_i = 8'hFF;
      @(posedge clk);
      #1;
      start_i = 1'b0;
      sendValue(vals[1], 1'b1, 20, acc);
      checkOutput("bp accept 1", {31'd0, acc}, 32'd1);
      repeat (8) @(posedge clk);
      #1;
      checkOutput("bp done once", doneSeen - doneBefore, 32'd1);
      checkOutput("bp writes drained", expQ.size(), 32'd0);
      checkOutput("bp count", {24'd0, count_o}, 32'd2);
      checkOutput("bp err", {31'd0, err_o}, 32'd0);
      checkOutput("bp mem 81", {24'd0, tbMem[8'h81]}, 32'h82);

      $display("[TB] reset during value write");
      expQ.push_back({8'h30, 8'h77});
      doneBefore = doneSeen;
      pulseStart(8'h30);
      sendValue(8'h77, 1'b1, 20, acc);
      checkOutput("rst accept", {31'd0, acc}, 32'd1);
      rst_i = 1'b0;
      @(posedge clk);
      #1;
      rst_i = 1'b1;
      mCount = 0;
      mErr = 1'b0;
      mSum = 8'h00;
      @(negedge clk);
      checkResetOutputs();
      repeat (6) @(posedge clk);
      #1;
      checkOutput("rst no done", doneSeen - doneBefore, 32'd0);
      checkOutput("rst writes drained", expQ.size(), 32'd0);
      vals[0] = 8'h01; vals[1] = 8'h02;
      applyStimulus("after rst", 8'h50, 2, 1);
      checkOutput("after rst mem 51", {24'd0, tbMem[8'h51]}, 32'h52);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
